eco_sweep_misr: RTL

Self-test harness stage wrapped around the 5-bit/5-bit → 3-bit combinational ECO test block. It drives that block's `A`/`B` operands through all 1024 input combinations and folds each 3-bit `Y` response into a multiple-input signature register (MISR). The final signature is compared against a golden value to confirm an ECO patch preserved function. It sits directly upstream (operand source) and downstream (response consumer) of the combinational block.

---
 rtl/eco_sweep_pkg.sv | 16 +
 rtl/eco_misr.sv | 37 +++
 rtl/eco_sweep_misr.sv | 93 +++++++++
 3 files changed

// File: rtl/eco_sweep_pkg.sv
// Shared types and constants for the ECO exhaustive-sweep signature harness.
package eco_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sweep_state_t;

   localparam int unsigned     VEC_W    = 10;
   localparam logic [VEC_W-1:0] VEC_LAST = 10'd1023;

   localparam logic [15:0] DEF_POLY = 16'h1021;
   localparam logic [15:0] DEF_SEED = 16'h0000;

endpackage

// File: rtl/eco_misr.sv
// Multiple-input signature register folding a 3-bit response per enabled cycle.
module eco_misr
   import eco_sweep_pkg::*;
#(
   parameter int unsigned      SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
   parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             clr,
   input  logic             en,
   input  logic [2:0]       din,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] r_sig;
   logic [SIG_W-1:0] w_sig_next;

   always_comb begin
      w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                 ^ (r_sig[SIG_W-1] ? POLY : '0)
                 ^ {{(SIG_W-3){1'b0}}, din};
   end

   // clr beats load beats en, so an abort never leaves a half-seeded register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_sig <= '0;
      else if (clr)  r_sig <= '0;
      else if (load) r_sig <= SEED;
      else if (en)   r_sig <= w_sig_next;
   end

   assign sig = r_sig;

endmodule

// File: rtl/eco_sweep_misr.sv
// Exhaustive 1024-vector operand sweep of the ECO block with MISR response compaction.
module eco_sweep_misr
   import eco_sweep_pkg::*;
#(
   parameter int unsigned      SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
   parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic [4:0]       a_o,
   output logic [4:0]       b_o,
   input  logic [2:0]       y_i,
   output logic             busy,
   output logic             done,
   output logic [SIG_W-1:0] signature,
   output logic [VEC_W-1:0] vec_idx
);

   sweep_state_t     r_state;
   sweep_state_t     w_state_next;
   logic [VEC_W-1:0] r_vec;
   logic [VEC_W-1:0] w_vec_next;
   logic             w_misr_load;
   logic             w_misr_clr;
   logic             w_misr_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_vec   <= '0;
      end else begin
         r_state <= w_state_next;
         r_vec   <= w_vec_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_vec_next   = r_vec;
      w_misr_load  = 1'b0;
      w_misr_clr   = 1'b0;
      w_misr_en    = 1'b0;
      if (abort) begin
         w_state_next = IDLE;
         w_vec_next   = '0;
         w_misr_clr   = 1'b1;
      end else begin
         unique case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  w_state_next = RUN;
                  w_vec_next   = '0;
                  w_misr_load  = 1'b1;
               end
            end
            RUN: begin
               // the vector on the operand bus is absorbed on this edge; last one parks the counter
               w_misr_en = 1'b1;
               if (r_vec == VEC_LAST) w_state_next = DONE;
               else                   w_vec_next   = r_vec + VEC_W'(1);
            end
            default: begin
               w_state_next = IDLE;
               w_vec_next   = '0;
            end
         endcase
      end
   end

   eco_misr #(
      .SIG_W (SIG_W),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (w_misr_load),
      .clr   (w_misr_clr),
      .en    (w_misr_en),
      .din   (y_i),
      .sig   (signature)
   );

   assign a_o     = r_vec[4:0];
   assign b_o     = r_vec[9:5];
   assign vec_idx = r_vec;
   assign busy    = (r_state == RUN);
   assign done    = (r_state == DONE);

endmodule
